// File: rtl/lc3_pkg.sv
// Shared LC3 control definitions: opcodes, memory-phase encodings and
// opcode-class helpers used by the pipeline controller.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_ST  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LDR = 4'd6;
  localparam logic [3:0] OP_STR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;
  localparam logic [3:0] OP_STI = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_LEA = 4'd14;

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_IND   = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_IDLE  = 2'd3
  } mem_state_e;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_HOLD = 1'b1
  } br_state_e;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer for loads and stores in execute.
//   state     | meaning
//   MEM_IDLE  | no access in flight, pipeline free to advance
//   MEM_IND   | reading the pointer for LDI/STI
//   MEM_READ  | data read for LD/LDR/LDI, completes writeback
//   MEM_WRITE | data write for ST/STR/STI
module lc3_mem_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_execute,
  input  logic       complete_data,
  input  logic [3:0] op_exec,
  output logic [1:0] mem_state,
  output logic       mem_stall,
  output logic       mem_wb
);
  import lc3_pkg::*;

  mem_state_e state;
  logic       ind_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MEM_IDLE;
      ind_load <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (enable_execute && (is_load(op_exec) || is_store(op_exec))) begin
            ind_load <= is_load(op_exec);
            if (op_exec == OP_LDI || op_exec == OP_STI) state <= MEM_IND;
            else if (is_load(op_exec))                  state <= MEM_READ;
            else                                        state <= MEM_WRITE;
          end
        end
        MEM_IND: begin
          if (complete_data) state <= ind_load ? MEM_READ : MEM_WRITE;
        end
        MEM_READ, MEM_WRITE: begin
          if (complete_data) state <= MEM_IDLE;
        end
      endcase
    end
  end

  assign mem_state = state;
  assign mem_stall = (state != MEM_IDLE);
  // Only the final read beat carries data into writeback.
  assign mem_wb    = (state == MEM_IDLE) || ((state == MEM_READ) && complete_data);

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: stage enables, branch fetch freeze and
// resolution, and ALU operand bypass selects for execute.
module lc3_pipe_ctrl #(
  parameter int BR_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);
  import lc3_pkg::*;

  localparam logic [1:0] BR_WAIT_C = 2'(BR_WAIT);

  logic        run;
  logic        mem_stall;
  logic        mem_wb;
  br_state_e   br_state;
  logic [1:0]  br_cnt;
  logic [15:0] br_ir;
  logic        resolve;
  logic [3:0]  op_ir;
  logic [3:0]  op_exec;
  logic        lint_unused;

  assign op_ir   = IR[15:12];
  assign op_exec = IR_Exec[15:12];

  // Outputs stay quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  lc3_mem_fsm u_mem_fsm (
    .clk            (clk),
    .rst            (rst),
    .enable_execute (enable_execute),
    .complete_data  (complete_data),
    .op_exec        (op_exec),
    .mem_state      (mem_state),
    .mem_stall      (mem_stall),
    .mem_wb         (mem_wb)
  );

  assign enable_execute   = run & ~mem_stall;
  assign enable_writeback = run & mem_wb;
  assign enable_decode    = run & ~mem_stall & complete_instr;
  assign enable_fetch     = enable_decode & (br_state == BR_IDLE);
  assign resolve          = enable_decode & (br_state == BR_HOLD) & (br_cnt == BR_WAIT_C);
  assign enable_updatePC  = enable_fetch | resolve;
  assign br_taken         = resolve & ((br_ir[15:12] == OP_JMP) | (|(br_ir[11:9] & psr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_state <= BR_IDLE;
      br_cnt   <= 2'd0;
      br_ir    <= 16'h0000;
    end else begin
      case (br_state)
        BR_IDLE: begin
          if (enable_fetch && is_ctrl(IMem_dout[15:12])) begin
            br_state <= BR_HOLD;
            br_cnt   <= 2'd1;
            br_ir    <= IMem_dout;
          end
        end
        BR_HOLD: begin
          if (resolve) begin
            br_state <= BR_IDLE;
            br_cnt   <= 2'd0;
          end else if (run && !mem_stall && br_cnt != BR_WAIT_C) begin
            br_cnt <= br_cnt + 2'd1;
          end
        end
      endcase
    end
  end

  assign bypass_alu_1 = run & is_alu(op_exec) & (IR_Exec[11:9] == IR[8:6]) &
                        (is_alu(op_ir) | (op_ir == OP_LDR) | (op_ir == OP_STR) |
                         (op_ir == OP_JMP));
  assign bypass_alu_2 = run & is_alu(op_exec) & (IR_Exec[11:9] == IR[2:0]) &
                        ((op_ir == OP_ADD) | (op_ir == OP_AND)) & ~IR[5];

  assign lint_unused = ^{IR[11:9], IR[4:3], IR_Exec[8:0], br_ir[8:0]};

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Scoreboard bench for lc3_pipe_ctrl: each stimulus cycle queues its
// expected output vector, a negedge monitor pops and compares.
module tb_lc3_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        complete_instr = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] IMem_dout = 16'h1000;
  logic [15:0] IR = 16'h0000;
  logic [15:0] IR_Exec = 16'h0000;
  logic [2:0]  psr = 3'b000;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        enable_updatePC, br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;

  // vector layout: {fetch, decode, execute, writeback, updatePC, br_taken, byp1, byp2, mem_state}
  localparam logic [9:0] RUN   = 10'b1111100011;
  localparam logic [9:0] RST_V = 10'b0000000011;
  localparam logic [9:0] HOLD  = 10'b0111000011;
  localparam logic [9:0] RES_T = 10'b0111110011;
  localparam logic [9:0] RES_N = 10'b0111100011;
  localparam logic [9:0] IND   = 10'b0000000001;
  localparam logic [9:0] RD    = 10'b0000000000;
  localparam logic [9:0] RD_WB = 10'b0001000000;
  localparam logic [9:0] WR    = 10'b0000000010;
  localparam logic [15:0] NOP  = 16'h1000;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;

  lc3_pipe_ctrl #(.BR_WAIT(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .IMem_dout        (IMem_dout),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatePC  (enable_updatePC),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .mem_state        (mem_state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic r, input logic ci, input logic cd,
                     input logic [15:0] im, input logic [15:0] ir_d,
                     input logic [15:0] ir_x, input logic [2:0] p, input logic [9:0] e);
    rst            = r;
    complete_instr = ci;
    complete_data  = cd;
    IMem_dout      = im;
    IR             = ir_d;
    IR_Exec        = ir_x;
    psr            = p;
    exp_q.push_back('{name: nm, v: e});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [9:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {enable_fetch, enable_decode, enable_execute, enable_writeback,
             enable_updatePC, br_taken, bypass_alu_1, bypass_alu_2, mem_state};
      checks++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset_hold", 0, 1, 0, NOP, 0, 0, 3'b000, RST_V);
    cyc("reset_release", 1, 1, 0, NOP, 0, 0, 3'b000, RST_V);
    cyc("first_run",     1, 1, 0, NOP, 0, 0, 3'b000, RUN);

    // LDI: indirect two cycles, read three cycles
    cyc("ldi_idle",  1, 1, 0, NOP, 0, 16'hA200, 3'b000, RUN);
    cyc("ldi_ind0",  1, 1, 0, NOP, 0, 16'hA200, 3'b000, IND);
    cyc("ldi_ind1",  1, 1, 1, NOP, 0, 16'hA200, 3'b000, IND);
    cyc("ldi_rd0",   1, 1, 0, NOP, 0, 16'hA200, 3'b000, RD);
    cyc("ldi_rd1",   1, 1, 0, NOP, 0, 16'hA200, 3'b000, RD);
    cyc("ldi_rd2",   1, 1, 1, NOP, 0, 16'hA200, 3'b000, RD_WB);
    cyc("ldi_done",  1, 1, 0, NOP, 0, 16'h0000, 3'b000, RUN);

    // STI and ST: writes never enable writeback
    cyc("sti_idle",  1, 1, 0, NOP, 0, 16'hB000, 3'b000, RUN);
    cyc("sti_ind",   1, 1, 1, NOP, 0, 16'hB000, 3'b000, IND);
    cyc("sti_wr",    1, 1, 1, NOP, 0, 16'hB000, 3'b000, WR);
    cyc("sti_done",  1, 1, 0, NOP, 0, 16'h0000, 3'b000, RUN);
    cyc("st_idle",   1, 1, 0, NOP, 0, 16'h3000, 3'b000, RUN);
    cyc("st_wr0",    1, 1, 0, NOP, 0, 16'h3000, 3'b000, WR);
    cyc("st_wr1",    1, 1, 1, NOP, 0, 16'h3000, 3'b000, WR);
    cyc("st_done",   1, 1, 0, NOP, 0, 16'h0000, 3'b000, RUN);

    // fetch stall: a BR seen without complete_instr must not start a hold
    cyc("ifetch_stall", 1, 0, 0, 16'h0E05, 0, 0, 3'b000, 10'b0011000011);
    cyc("ifetch_resume", 1, 1, 0, NOP, 0, 0, 3'b000, RUN);

    // BRnzp taken
    cyc("brt_fetch", 1, 1, 0, 16'h0E05, 0, 0, 3'b010, RUN);
    cyc("brt_hold1", 1, 1, 0, NOP, 0, 0, 3'b010, HOLD);
    cyc("brt_hold2", 1, 1, 0, NOP, 0, 0, 3'b010, HOLD);
    cyc("brt_resolve", 1, 1, 0, NOP, 0, 0, 3'b010, RES_T);
    cyc("brt_after", 1, 1, 0, NOP, 0, 0, 3'b010, RUN);

    // BRn not taken
    cyc("brn_fetch", 1, 1, 0, 16'h0805, 0, 0, 3'b001, RUN);
    cyc("brn_hold1", 1, 1, 0, NOP, 0, 0, 3'b001, HOLD);
    cyc("brn_hold2", 1, 1, 0, NOP, 0, 0, 3'b001, HOLD);
    cyc("brn_resolve", 1, 1, 0, NOP, 0, 0, 3'b001, RES_N);
    cyc("brn_after", 1, 1, 0, NOP, 0, 0, 3'b001, RUN);

    // JMP always taken
    cyc("jmp_fetch", 1, 1, 0, 16'hC1C0, 0, 0, 3'b000, RUN);
    cyc("jmp_hold1", 1, 1, 0, NOP, 0, 0, 3'b000, HOLD);
    cyc("jmp_hold2", 1, 1, 0, NOP, 0, 0, 3'b000, HOLD);
    cyc("jmp_resolve", 1, 1, 0, NOP, 0, 0, 3'b000, RES_T);
    cyc("jmp_after", 1, 1, 0, NOP, 0, 0, 3'b000, RUN);

    // bypass selects, producer ADD R2 in execute
    cyc("byp_both", 1, 1, 0, NOP, 16'h1682, 16'h1401, 3'b000, 10'b1111101111);
    cyc("byp_imm",  1, 1, 0, NOP, 16'h16A2, 16'h1401, 3'b000, 10'b1111101011);
    cyc("byp_sr2",  1, 1, 0, NOP, 16'h16C2, 16'h1401, 3'b000, 10'b1111100111);
    cyc("byp_str",  1, 1, 0, NOP, 16'h7280, 16'h1401, 3'b000, 10'b1111101011);
    cyc("byp_lea",  1, 1, 0, NOP, 16'h1682, 16'hE400, 3'b000, RUN);

    // BR fetched together with STR entering memory: counter freezes
    cyc("bst_fetch", 1, 1, 0, 16'h0E05, 0, 16'h7000, 3'b010, RUN);
    cyc("bst_wr1",   1, 1, 0, NOP, 0, 16'h7000, 3'b010, WR);
    cyc("bst_wr2",   1, 1, 0, NOP, 0, 16'h7000, 3'b010, WR);
    cyc("bst_wr3",   1, 1, 0, NOP, 0, 16'h7000, 3'b010, WR);
    cyc("bst_wr4",   1, 1, 1, NOP, 0, 16'h7000, 3'b010, WR);
    cyc("bst_cnt1",  1, 1, 0, NOP, 0, 16'h0000, 3'b010, HOLD);
    cyc("bst_cnt2",  1, 1, 0, NOP, 0, 16'h0000, 3'b010, HOLD);
    cyc("bst_resolve", 1, 1, 0, NOP, 0, 16'h0000, 3'b010, RES_T);
    cyc("bst_after", 1, 1, 0, NOP, 0, 16'h0000, 3'b010, RUN);

    // reset in the middle of a branch hold
    cyc("rb_fetch",  1, 1, 0, 16'h0E05, 0, 0, 3'b010, RUN);
    cyc("rb_hold",   1, 1, 0, NOP, 0, 0, 3'b010, HOLD);
    cyc("rb_reset",  0, 1, 0, NOP, 0, 0, 3'b010, RST_V);
    cyc("rb_release", 1, 1, 0, NOP, 0, 0, 3'b010, RST_V);
    cyc("rb_run",    1, 1, 0, NOP, 0, 0, 3'b010, RUN);

    // reset in the middle of a load
    cyc("ra_ld",     1, 1, 0, NOP, 0, 16'h2000, 3'b000, RUN);
    cyc("ra_read",   1, 1, 0, NOP, 0, 16'h2000, 3'b000, RD);
    cyc("ra_reset",  0, 1, 0, NOP, 0, 16'h0000, 3'b000, RST_V);
    cyc("ra_release", 1, 1, 0, NOP, 0, 16'h0000, 3'b000, RST_V);
    cyc("ra_run",    1, 1, 0, NOP, 0, 16'h0000, 3'b000, RUN);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_ctrl.md
# lc3_pipe_ctrl

Pipeline controller for the LC3 core. It sequences fetch, decode, execute, writeback and PC update through per-stage enables. It runs the data-memory state machine for loads and stores, and stalls fetch behind BR/JMP until the branch resolves. It also drives the ALU operand bypass selects for the execute stage.

## Interface
Parameters:
- BR_WAIT, default 3: cycles fetch is frozen after a BR/JMP is fetched; resolution happens in the last of these cycles.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- complete_instr  in  1  instruction memory has returned IMem_dout this cycle.
- complete_data  in  1  data memory access finished this cycle.
- IMem_dout  in  16  instruction currently being fetched.
- IR  in  16  instruction held in decode.
- IR_Exec  in  16  instruction held in execute.
- psr  in  3  NZP flags from writeback.
- enable_fetch  out  1  fetch stage enable.
- enable_decode  out  1  decode stage enable.
- enable_execute  out  1  execute stage enable.
- enable_writeback  out  1  writeback stage enable.
- enable_updatePC  out  1  PC register load enable.
- br_taken  out  1  PC mux selects the branch target.
- bypass_alu_1  out  1  aluin1 takes the execute result instead of VSR1.
- bypass_alu_2  out  1  aluin2 takes the execute result instead of VSR2.
- mem_state  out  2  data memory phase: 0 = read, 1 = indirect address read, 2 = write, 3 = idle.

## Operation
- Opcode classes are defined on bits [15:12]:
  - ALU: ADD=1, AND=5, NOT=9.
  - Load: LD=2, LDR=6, LDI=10.
  - Store: ST=3, STR=7, STI=11.
  - Control: BR=0, JMP=12.
  - LEA=14.
- Memory FSM (registered mem_state, reset value 3):
  - Entry from IDLE happens when enable_execute is high and IR_Exec is a load or store.
  - LD/LDR go to READ.
  - ST/STR go to WRITE.
  - LDI/STI go to INDIRECT.
- Memory FSM transitions out of non-idle states occur only in a cycle where complete_data=1:
  - INDIRECT goes to READ (LDI) or WRITE (STI); the opcode is latched on entry.
  - READ and WRITE go to IDLE.
  - Without complete_data, the state holds indefinitely.
- Memory stall: while mem_state != 3, the fetch, decode, execute and updatePC enables are all 0.
- enable_writeback during the memory FSM:
  - 1 in IDLE.
  - 1 in the READ cycle where complete_data=1.
  - 0 otherwise.
- Instruction-fetch stall: complete_instr=0 forces enable_fetch, enable_decode and enable_updatePC to 0. Execute and writeback continue.
- Branch FSM has two states, BR_IDLE and BR_HOLD, with a 2-bit counter.
  - It leaves BR_IDLE when IMem_dout is BR/JMP, complete_instr=1 and enable_fetch=1.
  - On that transition it latches IMem_dout into br_ir and sets the counter to 1.
- Behaviour in BR_HOLD:
  - enable_fetch and enable_updatePC are 0.
  - The counter increments each cycle the memory FSM is IDLE and is frozen otherwise.
  - When the counter equals BR_WAIT, the branch resolves (see next bullet) and the FSM returns to BR_IDLE.
- Branch resolution cycle:
  - enable_updatePC=1.
  - br_taken=1 if br_ir is JMP, or if (br_ir[11:9] & psr) != 0.
- Bypass (combinational, gated by IR_Exec being an ALU op):
  - bypass_alu_1 = (IR_Exec[11:9] == IR[8:6]) and IR is ADD, AND, NOT, LDR, STR or JMP.
  - bypass_alu_2 = (IR_Exec[11:9] == IR[2:0]) and IR is ADD or AND with IR[5]=0.
- When no stall is active, all five enables are 1.

## Timing
- While rst=0: mem_state=3, branch FSM in BR_IDLE, counter 0, br_ir=0, and every other output is 0.
- Deasserting rst takes effect at the next rising edge. The first cycle after release has all enables at 1 if complete_instr=1.
- Enables, br_taken and bypass signals are combinational from current state and inputs, with zero-cycle latency.
- mem_state and the branch state update one cycle after the triggering condition.
- A BR/JMP fetched while the memory FSM is busy cannot be detected, because enable_fetch is 0.
- A load/store in execute while in BR_HOLD enters the memory FSM normally, and the branch counter freezes.
- Reset asserted mid-access or mid-branch returns all state to reset values immediately (asynchronous). No partial access is resumed.

## Structure
- Shared package lc3_pkg holds:
  - opcode constants;
  - mem_state encodings (MEM_READ=0, MEM_IND=1, MEM_WRITE=2, MEM_IDLE=3);
  - opcode-class functions (is_alu, is_load, is_store, is_ctrl).
- Sub-module lc3_mem_fsm holds the memory FSM and its stall output. Branch FSM, bypass and enable logic stay in the top.

## Test plan
- Reset: hold rst=0 for 3 cycles → mem_state=3, all enables 0, br_taken=0. Release with complete_instr=1 → all enables 1 next cycle.
- LDI: IR_Exec=16'hA200 (LDI); complete_data pulses after 2 cycles and again after 3 cycles.
  - mem_state sequence is 3→1 (held) →0 (held) →3.
  - enable_execute=0 throughout.
  - enable_writeback=1 only in the READ completion cycle.
- BR taken: fetch 16'h0E05 (BRnzp) with psr=3'b010 → enable_fetch=0 for 3 cycles. On the 3rd cycle, enable_updatePC=1 and br_taken=1.
- BR not taken: fetch 16'h0805 (BRn) with psr=3'b001 → resolution cycle has enable_updatePC=1, br_taken=0.
- Bypass:
  - IR_Exec=16'h1401 (ADD R2,R0,R1) with IR=16'h1682 (ADD R3,R2,R2) → bypass_alu_1=1, bypass_alu_2=1.
  - Same IR_Exec with IR=16'h16A2 (imm form) → bypass_alu_2=0.
- Branch during store: STR in execute with BR_HOLD counter=1 and complete_data delayed 4 cycles → counter holds at 1 until mem_state returns to 3. Resolution then occurs 2 cycles later.
